// File: rtl/extend.sv
// RV32 immediate extender: decodes the I/S/B/J immediate fields of an
// instruction word and presents the sign-extended result one cycle later.
module extend (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] In,
    input  logic [1:0]  ImmSrc,
    input  logic        in_valid,
    output logic [31:0] Imm_Ext,
    output logic        out_valid
);

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    // Every encoding is meaningful, so the J-type layout doubles as the default arm.
    function automatic logic [31:0] decode_imm(input logic [31:0] instr, input logic [1:0] sel);
        logic [31:0] imm;
        case (sel)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            default: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        endcase
        return imm;
    endfunction

    logic [31:0] imm_s;

    // Combinational decode of the current instruction word.
    always_comb begin
        imm_s = decode_imm(In, ImmSrc);
    end

    // Result register: loads only on valid input, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Imm_Ext <= 32'h0000_0000;
        end else if (in_valid) begin
            Imm_Ext <= imm_s;
        end else begin
            Imm_Ext <= Imm_Ext;
        end
    end

    // Valid flag tracks the input qualifier with one cycle of delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_extend.sv
// Scoreboard bench for extend: stimulus pushes expected immediates, a monitor
// pops and compares them whenever out_valid is seen, and checks hold/reset.
module tb_extend;

    logic        clk;
    logic        rst_n;
    logic [31:0] In;
    logic [1:0]  ImmSrc;
    logic        in_valid;
    logic [31:0] Imm_Ext;
    logic        out_valid;

    int checks;
    int failures;
    logic [31:0] sb[$];
    logic [31:0] last_imm;

    extend dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .In       (In),
        .ImmSrc   (ImmSrc),
        .in_valid (in_valid),
        .Imm_Ext  (Imm_Ext),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model built from arithmetic shifts rather than bit concatenation.
    function automatic logic [31:0] model(input logic [31:0] w, input logic [1:0] sel);
        logic signed [31:0] sw;
        logic [31:0] r;
        sw = $signed(w);
        case (sel)
            2'd0: r = 32'(sw >>> 20);
            2'd1: r = (32'(sw >>> 25) << 5) | 32'(w[11:7]);
            2'd2: r = (32'(sw >>> 31) << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
            default: r = (32'(sw >>> 31) << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Scrambles inputs mid-cycle, then applies the real values at the falling edge.
    task automatic drive(input logic [31:0] w, input logic [1:0] sel, input logic v, input logic [31:0] exp);
        @(posedge clk);
        #3;
        In = $urandom;
        ImmSrc = 2'($urandom_range(3, 0));
        @(negedge clk);
        In = w;
        ImmSrc = sel;
        in_valid = v;
        if (v) sb.push_back(exp);
    endtask

    // Monitor: compares on valid output, checks hold and reset values otherwise.
    initial begin
        logic [31:0] exp;
        last_imm = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                last_imm = 32'h0;
                check("reset_imm", Imm_Ext, 32'h0);
                check("reset_valid", {31'h0, out_valid}, 32'h0);
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: got %08h expected no output", Imm_Ext);
                end else begin
                    exp = sb.pop_front();
                    check("imm", Imm_Ext, exp);
                    last_imm = exp;
                end
            end else begin
                check("hold_imm", Imm_Ext, last_imm);
            end
            @(negedge clk);
            check("mid_cycle_stable", Imm_Ext, rst_n ? last_imm : 32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        logic [1:0]  s;
        logic        v;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        In = 32'h0;
        ImmSrc = 2'b00;
        in_valid = 1'b0;
        #1;
        check("reset_async_imm", Imm_Ext, 32'h0);
        check("reset_async_valid", {31'h0, out_valid}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Mixed-field word, all four formats back to back.
        drive(32'hB6F16175, 2'b00, 1'b1, 32'hFFFFFB6F);
        drive(32'hB6F16175, 2'b01, 1'b1, 32'hFFFFFB62);
        drive(32'hB6F16175, 2'b10, 1'b1, 32'hFFFFF362);
        drive(32'hB6F16175, 2'b11, 1'b1, 32'hFFF16B6E);
        drive(32'h7FF00013, 2'b00, 1'b1, 32'h000007FF);
        drive(32'hFFFFFFFF, 2'b00, 1'b1, 32'hFFFFFFFF);
        drive(32'hFFFFFFFF, 2'b01, 1'b1, 32'hFFFFFFFF);
        drive(32'hFFFFFFFF, 2'b10, 1'b1, 32'hFFFFFFFE);
        drive(32'hFFFFFFFF, 2'b11, 1'b1, 32'hFFFFFFFE);
        drive(32'h00000000, 2'b11, 1'b1, 32'h00000000);
        // Idle cycles with a changed word: output must hold.
        drive(32'h12345678, 2'b00, 1'b0, 32'h0);
        drive(32'h87654321, 2'b10, 1'b0, 32'h0);
        drive(32'h7FF00013, 2'b00, 1'b1, 32'h000007FF);

        // Reset between edges while a result is valid and another is in flight.
        drive(32'h80000000, 2'b00, 1'b1, 32'hFFFFF800);
        #2;
        rst_n = 1'b0;
        sb.delete();
        in_valid = 1'b0;
        #1;
        check("midreset_imm", Imm_Ext, 32'h0);
        check("midreset_valid", {31'h0, out_valid}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(32'h00100093, 2'b00, 1'b1, 32'h00000001);
        drive(32'h00100093, 2'b00, 1'b0, 32'h0);

        // Random stream against the reference model.
        for (int i = 0; i < 300; i++) begin
            w = $urandom;
            s = 2'($urandom_range(3, 0));
            v = ($urandom_range(3, 0) != 0);
            drive(w, s, v, model(w, s));
        end

        drive(32'h0, 2'b00, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
